// File: rtl/led_serial_tx.sv
// Serialises a DATA_W-bit frame MSB-first onto an SDI/SCLK/LE shift-register LED driver chain,
// with a single-entry pending buffer so a strobe arriving mid-frame is queued rather than lost.
module led_serial_tx #(
   parameter int DATA_W  = 128,
   parameter int CLK_DIV = 2,
   parameter int LE_CYC  = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              enable,
   input  logic [DATA_W-1:0] data_in,
   output logic              led_sclk,
   output logic              led_sdi,
   output logic              led_le,
   output logic              busy,
   output logic              done,
   output logic              overrun
);

   localparam int BW = $clog2(DATA_W);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
   localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [7:0]    LE_LAST  = 8'(LE_CYC - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, LATCH, FIN} state_t;

   state_t            r_state;
   logic [DATA_W-2:0] r_shreg;
   logic [DATA_W-1:0] r_pendData;
   logic              r_pendValid;
   logic              r_phase;
   logic [BW-1:0]     r_bitCnt;
   logic [7:0]        r_divCnt;
   logic [7:0]        r_leCnt;
   logic              r_sclk, r_sdi, r_le, r_busy, r_done, r_overrun;

   logic              w_start;
   logic [DATA_W-1:0] w_startData;

   // A queued word always takes priority over a fresh strobe when a frame finishes.
   always_comb begin
      w_start     = 1'b0;
      w_startData = data_in;
      if (r_state == IDLE) begin
         w_start = enable;
      end else if (r_state == FIN) begin
         w_start = r_pendValid | enable;
         if (r_pendValid) begin
            w_startData = r_pendData;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= IDLE;
         r_shreg     <= '0;
         r_pendData  <= '0;
         r_pendValid <= 1'b0;
         r_phase     <= 1'b0;
         r_bitCnt    <= '0;
         r_divCnt    <= '0;
         r_leCnt     <= '0;
         r_sclk      <= 1'b0;
         r_sdi       <= 1'b0;
         r_le        <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_overrun <= 1'b0;

         if (enable && (r_state == SHIFT || r_state == LATCH)) begin
            r_pendData  <= data_in;
            r_pendValid <= 1'b1;
            r_overrun   <= r_pendValid;
         end else if (r_state == FIN && r_pendValid) begin
            if (enable) begin
               r_pendData <= data_in;
            end else begin
               r_pendValid <= 1'b0;
            end
         end

         case (r_state)
            IDLE, FIN: begin
               if (w_start) begin
                  r_state  <= SHIFT;
                  r_shreg  <= w_startData[DATA_W-2:0];
                  r_sdi    <= w_startData[DATA_W-1];
                  r_sclk   <= 1'b0;
                  r_busy   <= 1'b1;
                  r_phase  <= 1'b0;
                  r_divCnt <= '0;
                  r_bitCnt <= '0;
               end else begin
                  r_state <= IDLE;
               end
            end
            SHIFT: begin
               if (r_divCnt == DIV_LAST) begin
                  r_divCnt <= '0;
                  if (!r_phase) begin
                     r_phase <= 1'b1;
                     r_sclk  <= 1'b1;
                  end else if (r_bitCnt == BIT_LAST) begin
                     r_state <= LATCH;
                     r_phase <= 1'b0;
                     r_sclk  <= 1'b0;
                     r_sdi   <= 1'b0;
                     r_le    <= 1'b1;
                     r_leCnt <= '0;
                  end else begin
                     r_bitCnt <= r_bitCnt + 1'b1;
                     r_phase  <= 1'b0;
                     r_sclk   <= 1'b0;
                     r_sdi    <= r_shreg[DATA_W-2];
                     r_shreg  <= {r_shreg[DATA_W-3:0], 1'b0};
                  end
               end else begin
                  r_divCnt <= r_divCnt + 1'b1;
               end
            end
            LATCH: begin
               if (r_leCnt == LE_LAST) begin
                  r_state <= FIN;
                  r_le    <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_leCnt <= r_leCnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign led_sclk = r_sclk;
   assign led_sdi  = r_sdi;
   assign led_le   = r_le;
   assign busy     = r_busy;
   assign done     = r_done;
   assign overrun  = r_overrun;

endmodule

// File: tb/tb_led_serial_tx.sv
// Self-checking bench for led_serial_tx: a frame-level timing model predicts every output each cycle,
// plus directed checks on edge counts, done/overrun timing and transmitted words.
module tb_led_serial_tx;

   localparam int W        = 128;
   localparam int D        = 2;
   localparam int LEC      = 4;
   localparam int SHIFTLEN = 2 * D * W;
   localparam int FRAMELEN = SHIFTLEN + LEC + 1;

   logic         clk = 1'b0;
   logic         rstn;
   logic         enable, enable1;
   logic [W-1:0] dataIn, dataIn1;
   logic         sclk, sdi, le, busy, done, overrun;
   logic         sclk1, sdi1, le1, busy1, done1, overrun1;

   always #5 clk = ~clk;

   led_serial_tx #(.DATA_W(W), .CLK_DIV(D), .LE_CYC(LEC)) u_dut (
      .clk(clk), .rstn(rstn), .enable(enable), .data_in(dataIn),
      .led_sclk(sclk), .led_sdi(sdi), .led_le(le),
      .busy(busy), .done(done), .overrun(overrun)
   );

   led_serial_tx #(.DATA_W(W), .CLK_DIV(1), .LE_CYC(1)) u_dutFast (
      .clk(clk), .rstn(rstn), .enable(enable1), .data_in(dataIn1),
      .led_sclk(sclk1), .led_sdi(sdi1), .led_le(le1),
      .busy(busy1), .done(done1), .overrun(overrun1)
   );

   int errors = 0;
   int checks = 0;

   // Frame-level reference: when the current frame started and what it carries, plus the pending word.
   longint       cyc = 0;
   logic         mActive, mPendV, mOvr;
   longint       mStart;
   logic [W-1:0] mData, mPend;

   typedef struct {int at; logic [W-1:0] d;} stim_t;
   stim_t stimQ[$];

   int   rel;
   int   doneAt[$];
   int   ovrAt[$];
   int   riseAt[$];
   int   leAt[$];
   logic sdiBits[$];
   int   busyLow;
   int   busyWinEnd;
   logic prevSclk;

   task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic modelReset();
      mActive = 1'b0;
      mPendV  = 1'b0;
      mOvr    = 1'b0;
      mStart  = 0;
      mData   = '0;
      mPend   = '0;
   endtask

   // Expected {sclk, sdi, le, busy, done, overrun} for the current cycle.
   function automatic logic [5:0] modelOut();
      logic [5:0] r;
      longint     p;
      r = 6'b0;
      if (mActive) begin
         p = cyc - mStart;
         if (p < SHIFTLEN) begin
            r[5] = ((p % (2 * D)) >= D);
            r[4] = mData[W - 1 - int'(p / (2 * D))];
            r[2] = 1'b1;
         end else if (p < SHIFTLEN + LEC) begin
            r[3] = 1'b1;
            r[2] = 1'b1;
         end else begin
            r[1] = 1'b1;
         end
      end
      r[0] = mOvr;
      return r;
   endfunction

   task automatic modelStep(input logic en, input logic [W-1:0] d);
      longint p;
      logic   nOvr;
      if (!rstn) begin
         modelReset();
         return;
      end
      nOvr = 1'b0;
      if (!mActive) begin
         if (en) begin
            mActive = 1'b1;
            mStart  = cyc + 1;
            mData   = d;
         end
      end else begin
         p = cyc - mStart;
         if (p < FRAMELEN - 1) begin
            if (en) begin
               nOvr   = mPendV;
               mPend  = d;
               mPendV = 1'b1;
            end
         end else if (mPendV) begin
            mStart = cyc + 1;
            mData  = mPend;
            if (en) mPend = d;
            else    mPendV = 1'b0;
         end else if (en) begin
            mStart = cyc + 1;
            mData  = d;
         end else begin
            mActive = 1'b0;
         end
      end
      mOvr = nOvr;
   endtask

   task automatic clearRecords();
      doneAt.delete();
      ovrAt.delete();
      riseAt.delete();
      leAt.delete();
      sdiBits.delete();
      busyLow  = 0;
      prevSclk = 1'b0;
      rel      = 0;
   endtask

   // Called at a falling edge: check this cycle, then drive this cycle's inputs.
   task automatic stepCycle(input logic en, input logic [W-1:0] d);
      logic [5:0] obs;
      obs = {sclk, sdi, le, busy, done, overrun};
      checkOutput($sformatf("cycle%0d", rel), W'(obs), W'(modelOut()));
      if (done)    doneAt.push_back(rel);
      if (overrun) ovrAt.push_back(rel);
      if (le)      leAt.push_back(rel);
      if (sclk && !prevSclk) begin
         riseAt.push_back(rel);
         sdiBits.push_back(sdi);
      end
      if (!busy && rel >= 1 && rel <= busyWinEnd) busyLow++;
      prevSclk = sclk;
      enable   = en;
      dataIn   = d;
      modelStep(en, d);
      @(negedge clk);
      cyc++;
      rel++;
   endtask

   task automatic applyStimulus(input int nCycles);
      logic         en;
      logic [W-1:0] d;
      clearRecords();
      for (int i = 0; i < nCycles; i++) begin
         en = 1'b0;
         d  = rand128();
         foreach (stimQ[j]) begin
            if (stimQ[j].at == i) begin
               en = 1'b1;
               d  = stimQ[j].d;
            end
         end
         stepCycle(en, d);
      end
      stimQ.delete();
   endtask

   function automatic logic [W-1:0] bitsAsWord(input int off);
      logic [W-1:0] w;
      w = '0;
      for (int i = 0; i < W; i++) begin
         if (off + i < sdiBits.size()) w[W-1-i] = sdiBits[off + i];
      end
      return w;
   endfunction

   task automatic runFastDivider();
      logic [W-1:0] d;
      int           rises[$];
      logic [W-1:0] got;
      int           doneCyc, leCnt, r;
      logic         prev;
      d       = rand128();
      got     = '0;
      doneCyc = -1;
      leCnt   = 0;
      prev    = 1'b0;
      enable1 = 1'b1;
      dataIn1 = d;
      @(negedge clk);
      enable1 = 1'b0;
      dataIn1 = rand128();
      for (int c = 1; c <= 270; c++) begin
         if (sclk1 && !prev) begin
            r = rises.size();
            if (r < W) got[W-1-r] = sdi1;
            rises.push_back(c);
         end
         if (done1) doneCyc = c;
         if (le1) leCnt++;
         prev = sclk1;
         @(negedge clk);
      end
      checkOutput("fastRiseCount", W'(rises.size()), W'(W));
      for (int k = 0; k < W && k < rises.size(); k += 31) begin
         checkOutput($sformatf("fastRise%0d", k), W'(rises[k]), W'(2 + 2 * k));
      end
      if (rises.size() == W) checkOutput("fastLastRise", W'(rises[W-1]), W'(256));
      checkOutput("fastDone", W'(doneCyc), W'(258));
      checkOutput("fastLeCycles", W'(leCnt), W'(1));
      checkOutput("fastData", got, d);
   endtask

   logic [W-1:0] a, b, c;
   int           t;

   initial begin
      rstn       = 1'b0;
      enable     = 1'b0;
      enable1    = 1'b0;
      dataIn     = '0;
      dataIn1    = '0;
      busyWinEnd = 0;
      modelReset();
      clearRecords();
      @(negedge clk);

      $display("[TB] reset hold with random inputs");
      for (int i = 0; i < 5; i++) stepCycle(1'($urandom_range(0, 1)), rand128());
      rstn = 1'b1;
      applyStimulus(100);
      checkOutput("idleNoDone", W'(doneAt.size()), W'(0));

      $display("[TB] single frame");
      a = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
      stimQ.push_back('{0, a});
      applyStimulus(530);
      checkOutput("singleDoneCount", W'(doneAt.size()), W'(1));
      if (doneAt.size() > 0) checkOutput("singleDoneAt", W'(doneAt[0]), W'(517));
      checkOutput("singleRiseCount", W'(riseAt.size()), W'(128));
      if (riseAt.size() == 128) begin
         checkOutput("singleFirstRise", W'(riseAt[0]), W'(3));
         checkOutput("singleLastRise", W'(riseAt[127]), W'(511));
      end
      checkOutput("singleBits", bitsAsWord(0), a);
      checkOutput("singleLeCount", W'(leAt.size()), W'(4));
      if (leAt.size() > 0) checkOutput("singleLeFirst", W'(leAt[0]), W'(513));

      $display("[TB] pattern frames");
      a = {32{4'h5}};
      stimQ.push_back('{0, a});
      applyStimulus(520);
      checkOutput("pattern55Bits", bitsAsWord(0), a);
      a = '1;
      stimQ.push_back('{0, a});
      applyStimulus(520);
      checkOutput("patternOnesBits", bitsAsWord(0), a);

      $display("[TB] back-to-back via pending");
      a = rand128();
      b = rand128();
      busyWinEnd = 1033;
      stimQ.push_back('{0, a});
      stimQ.push_back('{200, b});
      applyStimulus(1040);
      busyWinEnd = 0;
      checkOutput("b2bDoneCount", W'(doneAt.size()), W'(2));
      if (doneAt.size() == 2) begin
         checkOutput("b2bDoneA", W'(doneAt[0]), W'(517));
         checkOutput("b2bDoneB", W'(doneAt[1]), W'(1034));
      end
      checkOutput("b2bBusyLow", W'(busyLow), W'(1));
      checkOutput("b2bOverrun", W'(ovrAt.size()), W'(0));
      if (riseAt.size() > 128) checkOutput("b2bFirstRiseB", W'(riseAt[128]), W'(520));
      checkOutput("b2bBitsB", bitsAsWord(128), b);

      $display("[TB] overrun");
      a = rand128();
      b = rand128();
      c = rand128();
      stimQ.push_back('{0, a});
      stimQ.push_back('{100, b});
      stimQ.push_back('{300, c});
      applyStimulus(1040);
      checkOutput("ovrCount", W'(ovrAt.size()), W'(1));
      if (ovrAt.size() > 0) checkOutput("ovrAt", W'(ovrAt[0]), W'(301));
      checkOutput("ovrSecondFrame", bitsAsWord(128), c);

      $display("[TB] strobe during finish with pending word");
      stimQ.push_back('{0, a});
      stimQ.push_back('{100, b});
      stimQ.push_back('{517, c});
      applyStimulus(1560);
      checkOutput("finOverrun", W'(ovrAt.size()), W'(0));
      checkOutput("finDoneCount", W'(doneAt.size()), W'(3));
      if (doneAt.size() == 3) checkOutput("finThirdDone", W'(doneAt[2]), W'(1551));
      checkOutput("finSecondFrame", bitsAsWord(128), b);
      checkOutput("finThirdFrame", bitsAsWord(256), c);

      $display("[TB] reset mid-frame");
      stimQ.push_back('{0, a});
      applyStimulus(250);
      rstn = 1'b0;
      #1;
      checkOutput("asyncReset", W'({sclk, sdi, le, busy, done, overrun}), W'(0));
      checkOutput("abortNoDone", W'(doneAt.size()), W'(0));
      modelReset();
      for (int i = 0; i < 3; i++) stepCycle(1'($urandom_range(0, 1)), rand128());
      rstn = 1'b1;
      b = rand128();
      stimQ.push_back('{5, b});
      applyStimulus(540);
      checkOutput("afterResetDone", W'(doneAt.size() == 1 ? doneAt[0] : -1), W'(522));
      checkOutput("afterResetBits", bitsAsWord(0), b);

      $display("[TB] random strobes");
      t = 0;
      for (int i = 0; i < 10; i++) begin
         t += $urandom_range(40, 700);
         stimQ.push_back('{t, rand128()});
      end
      applyStimulus(t + 1200);

      $display("[TB] fast divider instance");
      runFastDivider();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
